// File: rtl/cmp_rr_arbiter.sv
// cmp_rr_arbiter
// Shares a single WIDTH-bit unsigned magnitude comparator among NREQ requesters.
// A round-robin arbiter picks one requester, latches its operand pair, and the
// next cycle returns registered greater/equal/lower flags tagged with the
// requester index.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request (bit i -> slice i of a_in/b_in is valid)
//   a_in       operand A, slice i = a_in[i*WIDTH +: WIDTH]
//   b_in       operand B, slice i = b_in[i*WIDTH +: WIDTH]
//   gnt        one-hot registered grant pulse
//   busy       high while a comparison is in flight
//   res_valid  one-cycle pulse, flags and res_id valid
//   res_id     requester index the result belongs to
//   greater    latched A > B
//   equal      latched A == B
//   lower      latched A < B
//
// State | meaning
// ARB   | waiting for a request; picks the round-robin winner and latches operands
// CMP   | comparing the latched operands; result registered on the way back to ARB
module cmp_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  res_valid,
    output logic [IDW-1:0]        res_id,
    output logic                  greater,
    output logic                  equal,
    output logic                  lower
);

    typedef enum logic {ARB = 1'b0, CMP = 1'b1} state_t;

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t               state, state_nx;
    logic [IDW-1:0]       rr_ptr, rr_ptr_nx;
    logic [IDW-1:0]       id_r, id_r_nx;
    logic [WIDTH-1:0]     op_a, op_a_nx;
    logic [WIDTH-1:0]     op_b, op_b_nx;
    logic [NREQ-1:0]      gnt_nx;
    logic                 busy_nx;
    logic                 res_valid_nx;
    logic [IDW-1:0]       res_id_nx;
    logic                 greater_nx, equal_nx, lower_nx;

    logic                 win_found;
    logic [IDW-1:0]       win_id;
    logic [IDW-1:0]       scan;

    // Walk upward from rr_ptr with wrap; the first set bit wins. The wrap is
    // explicit so non-power-of-two NREQ never indexes past the last requester.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan      = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[scan]) begin
                win_found = 1'b1;
                win_id    = scan;
            end
            scan = (scan == LAST_ID) ? '0 : scan + IDW'(1);
        end
    end

    always_comb begin
        state_nx     = state;
        rr_ptr_nx    = rr_ptr;
        id_r_nx      = id_r;
        op_a_nx      = op_a;
        op_b_nx      = op_b;
        gnt_nx       = gnt;
        busy_nx      = busy;
        res_valid_nx = 1'b0;
        res_id_nx    = res_id;
        greater_nx   = greater;
        equal_nx     = equal;
        lower_nx     = lower;
        case (state)
            ARB: begin
                if (win_found) begin
                    op_a_nx  = a_in[win_id*WIDTH +: WIDTH];
                    op_b_nx  = b_in[win_id*WIDTH +: WIDTH];
                    id_r_nx  = win_id;
                    gnt_nx   = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                    busy_nx  = 1'b1;
                    state_nx = CMP;
                end else begin
                    gnt_nx  = '0;
                    busy_nx = 1'b0;
                end
            end
            CMP: begin
                // req is deliberately ignored here, so a requester dropping
                // its request one edge after the grant is never granted twice.
                greater_nx   = (op_a > op_b);
                equal_nx     = (op_a == op_b);
                lower_nx     = (op_a < op_b);
                res_id_nx    = id_r;
                res_valid_nx = 1'b1;
                gnt_nx       = '0;
                busy_nx      = 1'b0;
                rr_ptr_nx    = (id_r == LAST_ID) ? '0 : id_r + IDW'(1);
                state_nx     = ARB;
            end
            default: begin
                state_nx = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB;
            rr_ptr    <= '0;
            id_r      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            greater   <= 1'b0;
            equal     <= 1'b0;
            lower     <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            id_r      <= id_r_nx;
            op_a      <= op_a_nx;
            op_b      <= op_b_nx;
            gnt       <= gnt_nx;
            busy      <= busy_nx;
            res_valid <= res_valid_nx;
            res_id    <= res_id_nx;
            greater   <= greater_nx;
            equal     <= equal_nx;
            lower     <= lower_nx;
        end
    end

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
module tb_cmp_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 3;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] a_in = '0;
    logic [NREQ*WIDTH-1:0] b_in = '0;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic                  greater;
    logic                  equal;
    logic                  lower;

    int compared   = 0;
    int mismatched = 0;

    cmp_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .greater(greater), .equal(equal), .lower(lower)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one grant is "in flight" for a single
    // cycle; the winner is the first requester at or after the pointer.
    bit  m_fly = 0;
    int  m_ptr = 0, m_id = 0, m_a = 0, m_b = 0, m_c = 0;
    bit  m_found = 0;
    int  e_gnt = 0, e_id = 0;
    bit  e_busy = 0, e_rv = 0, e_g = 0, e_e = 0, e_l = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fly = 0; m_ptr = 0; m_id = 0; m_a = 0; m_b = 0;
            e_gnt = 0; e_id = 0; e_busy = 0; e_rv = 0; e_g = 0; e_e = 0; e_l = 0;
        end else if (m_fly) begin
            m_fly  = 0;
            e_rv   = 1;
            e_id   = m_id;
            e_g    = (m_a > m_b);
            e_e    = (m_a == m_b);
            e_l    = (m_a < m_b);
            e_gnt  = 0;
            e_busy = 0;
            m_ptr  = (m_id + 1) % NREQ;
        end else begin
            e_rv = 0;
            m_found = 0;
            for (int k = 0; k < NREQ; k++) begin
                m_c = (m_ptr + k) % NREQ;
                if (!m_found && req[m_c]) begin
                    m_found = 1;
                    m_id = m_c;
                end
            end
            if (m_found) begin
                m_fly  = 1;
                m_a    = int'(a_in[m_id*WIDTH +: WIDTH]);
                m_b    = int'(b_in[m_id*WIDTH +: WIDTH]);
                e_gnt  = 1 << m_id;
                e_busy = 1;
            end else begin
                e_gnt  = 0;
                e_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt",       int'(gnt),       e_gnt);
        chk("busy",      int'(busy),      int'(e_busy));
        chk("res_valid", int'(res_valid), int'(e_rv));
        chk("res_id",    int'(res_id),    e_id);
        chk("greater",   int'(greater),   int'(e_g));
        chk("equal",     int'(equal),     int'(e_e));
        chk("lower",     int'(lower),     int'(e_l));
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
        b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic single(input int i, input int a, input int b,
                          input int g, input int e, input int l);
        req = '0;
        req[i] = 1'b1;
        set_ops(i, a, b);
        wait_edge();
        chk("single_gnt", int'(gnt), 1 << i);
        chk("single_rv_early", int'(res_valid), 0);
        req = '0;
        wait_edge();
        chk("single_rv", int'(res_valid), 1);
        chk("single_id", int'(res_id), i);
        chk("single_flags", int'({greater, equal, lower}), (g << 2) | (e << 1) | l);
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // reset values
        #2;
        chk("reset_outputs", int'({gnt, busy, res_valid, res_id, greater, equal, lower}), 0);
        rst_n = 1'b1;

        // run with all requesting, then reset asynchronously mid-run
        req = 4'b1111;
        wait_edge(); wait_edge(); wait_edge();
        chk("pre_reset_gnt", int'(gnt), 4'b0010);
        chk("pre_reset_equal", int'(equal), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", int'({gnt, busy, res_valid, res_id, greater, equal, lower}), 0);
        req = 4'b0001;
        set_ops(0, 0, 0);
        #2 rst_n = 1'b1;
        wait_edge();
        chk("post_reset_gnt", int'(gnt), 4'b0001);
        chk("post_reset_busy", int'(busy), 1);
        req = '0;
        wait_edge();
        chk("post_reset_rv", int'(res_valid), 1);
        chk("post_reset_id", int'(res_id), 0);
        chk("post_reset_equal", int'(equal), 1);

        // directed single requester
        single(1, 7, 5, 1, 0, 0);
        single(1, 4, 6, 0, 0, 1);
        single(1, 7, 7, 0, 1, 0);
        wait_edge();
        chk("rv_one_cycle", int'(res_valid), 0);

        // round robin from pointer 0
        single(3, 2, 2, 0, 1, 0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_edge();
            chk("rr_gnt", int'(gnt), 1 << order[k]);
            chk("rr_rv_gap", int'(res_valid), 0);
            wait_edge();
            chk("rr_rv", int'(res_valid), 1);
            chk("rr_id", int'(res_id), order[k]);
        end
        req = '0;
        wait_edge();

        // priority rotation after requester 2
        single(2, 1, 0, 1, 0, 0);
        req = 4'b0101;
        wait_edge();
        chk("rot_gnt0", int'(gnt), 4'b0001);
        req = 4'b0100;
        wait_edge();
        chk("rot_id0", int'(res_id), 0);
        wait_edge();
        chk("rot_gnt2", int'(gnt), 4'b0100);
        req = '0;
        wait_edge();
        chk("rot_id2", int'(res_id), 2);

        // operand change during CMP has no effect
        req = 4'b0001;
        set_ops(0, 1, 3);
        wait_edge();
        set_ops(0, 7, 3);
        req = '0;
        wait_edge();
        chk("stable_flags", int'({greater, equal, lower}), 3'b001);

        // reset during CMP discards the result
        req = 4'b0010;
        set_ops(1, 5, 2);
        wait_edge();
        chk("cmp_gnt", int'(gnt), 4'b0010);
        req = 4'b1000;
        #2 rst_n = 1'b0;
        wait_edge();
        chk("discard_rv", int'(res_valid), 0);
        #2 rst_n = 1'b1;
        wait_edge();
        chk("after_reset_gnt", int'(gnt), 4'b1000);
        req = '0;
        wait_edge();
        chk("after_reset_id", int'(res_id), 3);

        // randomized traffic with occasional async reset pulses
        for (int n = 0; n < 3000; n++) begin
            req  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ($urandom_range(0, 3) == 0) req = '0;
            a_in = (NREQ*WIDTH)'($urandom);
            b_in = (NREQ*WIDTH)'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            wait_edge();
        end
        req = '0;
        wait_edge(); wait_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
